// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth from address width and level/threshold compares.
package fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned pointer);
        return 32'd1 << pointer;
    endfunction

    function automatic logic level_at_or_above(input int unsigned level,
                                               input int unsigned threshold);
        return level >= threshold;
    endfunction

    function automatic logic level_at_or_below(input int unsigned level,
                                               input int unsigned threshold);
        return level <= threshold;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned POINTER = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [POINTER-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [POINTER-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    localparam int unsigned DEPTH = fifo_depth(POINTER);

    // Storage is deliberately left out of reset; stale words are unreachable via the pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level thresholds, fill level, sticky error flags and optional FWFT reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned POINTER  = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               wren,
    input  logic [WIDTH-1:0]   data_in,
    output logic               wr_full,
    output logic               wr_almost_full,
    output logic               overflow,
    input  logic               rden,
    output logic [WIDTH-1:0]   data_out,
    output logic               rd_empty,
    output logic               rd_almost_empty,
    output logic               underflow,
    output logic [POINTER:0]   fill_level
);

    localparam int unsigned DEPTH = fifo_depth(POINTER);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [POINTER:0]  wr_ptr_q, rd_ptr_q;
    logic              overflow_q, underflow_q;
    logic              wr_accept, rd_accept;
    logic [WIDTH-1:0]  ram_rdata;

    // Flags come only from registered pointers so they never combinationally depend on requests.
    always_comb begin
        fill_level      = wr_ptr_q - rd_ptr_q;
        rd_empty        = (wr_ptr_q == rd_ptr_q);
        wr_full         = (wr_ptr_q[POINTER-1:0] == rd_ptr_q[POINTER-1:0]) &&
                          (wr_ptr_q[POINTER] != rd_ptr_q[POINTER]);
        wr_almost_full  = level_at_or_above(32'(fill_level), AF_LEVEL);
        rd_almost_empty = level_at_or_below(32'(fill_level), AE_LEVEL);
        wr_accept       = wren && !wr_full;
        rd_accept       = rden && !rd_empty;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + (POINTER+1)'(1);
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + (POINTER+1)'(1);
            end
            if (wren && wr_full) begin
                overflow_q <= 1'b1;
            end
            if (rden && rd_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_ram #(
        .WIDTH   (WIDTH),
        .POINTER (POINTER)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[POINTER-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[POINTER-1:0]),
        .rd_data (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign data_out = ram_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] data_q;

        // Loaded only on an accepted read; holds across idle cycles and rejected reads.
        always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
                data_q <= '0;
            end else if (rd_accept) begin
                data_q <= ram_rdata;
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO. Parametrised successor of the dual-clock FIFO for same-domain buffering; needs no pointer synchronisers.
- Adds:
  - configurable depth and width;
  - almost-full and almost-empty thresholds;
  - a fill-level output;
  - a standard or first-word-fall-through (FWFT) read mode;
  - sticky overflow and underflow error flags.
- Sits between any same-clock producer/consumer pair in the datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- POINTER, 4, address width; DEPTH = 2**POINTER entries.
- AF_LEVEL, 12, wr_almost_full asserts when fill_level >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, rd_almost_empty asserts when fill_level <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- areset  in  1  asynchronous reset, active-high.
- wren  in  1  write request.
- data_in  in  WIDTH  write data.
- wr_full  out  1  FIFO holds DEPTH words.
- wr_almost_full  out  1  fill_level >= AF_LEVEL.
- overflow  out  1  sticky: write attempted while full.
- rden  in  1  read request.
- data_out  out  WIDTH  read data.
- rd_empty  out  1  FIFO holds 0 words.
- rd_almost_empty  out  1  fill_level <= AE_LEVEL.
- underflow  out  1  sticky: read attempted while empty.
- fill_level  out  POINTER+1  words currently stored, 0..DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - Asserting areset clears immediately, independent of clk: wr_ptr=0, rd_ptr=0, fill_level=0, wr_full=0, wr_almost_full=0, rd_empty=1, rd_almost_empty=1, overflow=0, underflow=0, data_out=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words.
  - First accepted write is the first rising edge with areset low.
- Pointers:
  - wr_ptr and rd_ptr are POINTER+1 bits; memory is indexed by [POINTER-1:0].
  - Natural binary wrap from 2**(POINTER+1)-1 to 0.
  - fill_level = wr_ptr - rd_ptr, modulo 2**(POINTER+1).
- Flags:
  - wr_full = (low bits equal) and (MSBs differ).
  - rd_empty = (pointers equal).
  - wr_almost_full and rd_almost_empty compare fill_level against AF_LEVEL and AE_LEVEL.
  - All flags are combinational from registered pointers only, never from wren/rden.
- Write accept: wren=1 and wr_full=0 -> mem[wr_ptr] <= data_in, wr_ptr+1.
- Read accept: rden=1 and rd_empty=0 -> rd_ptr+1.
- Rejected requests:
  - wren=1 while wr_full=1: no state change except overflow <= 1.
  - rden=1 while rd_empty=1: no state change except underflow <= 1.
  - Both error flags clear only on areset.
- Simultaneous write and read in one cycle:
  - Both are accepted when neither flag blocks them; fill_level is unchanged.
  - Full with both asserted: read accepted, write rejected, overflow set. fill_level goes DEPTH -> DEPTH-1.
  - Empty with both asserted: write accepted, read rejected, underflow set. fill_level goes 0 -> 1.
- Standard mode, FWFT=0:
  - data_out is a register loaded with mem[rd_ptr] on the edge that accepts a read.
  - Word is valid the cycle after rden is accepted.
  - data_out holds its value otherwise, including on rejected reads.
- FWFT mode, FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever rd_empty=0. The head word is valid with no rden.
  - rden acknowledges (pops) it.
  - data_out is don't-care while rd_empty=1.
- Write-to-read latency: a word written on edge N deasserts rd_empty after edge N. It is readable (FWFT) or requestable (standard) in cycle N+1.
- No write-through bypass: a simultaneous write to an empty FIFO is not readable in the same cycle.

Decomposition:
- Shared package fifo_pkg: DEPTH computation helper, and the level and flag-comparison function used by this block and the dual-clock FIFO.
- Sub-module fifo_ram: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port. The top level adds an output register when FWFT=0.
- Elaboration-time check rejects AF_LEVEL/AE_LEVEL outside their legal ranges.

Test Plan:
- Reset: areset=1 mid-run with fill_level=7 -> immediately rd_empty=1, wr_full=0, fill_level=0, overflow=underflow=0; the next read after release sets underflow.
- Fill: WIDTH=8, POINTER=4, write 0x00..0x0F -> wr_almost_full rises after the 12th write; wr_full=1 and fill_level=16 after the 16th; a 17th write sets overflow=1 and leaves memory and level unchanged.
- Drain, FWFT=0: from full, rden held 16 cycles -> data_out 0x00..0x0F each one cycle after acceptance; rd_almost_empty rises when fill_level=2; rd_empty=1 after the last read; data_out holds 0x0F.
- FWFT=1: write 0xA5 to an empty FIFO -> next cycle rd_empty=0 and data_out=0xA5 with rden=0; rden pulse -> rd_empty=1.
- Simultaneous: at fill_level=16, wren=rden=1 -> fill_level=15, overflow=1; at fill_level=0, both -> fill_level=1, underflow=1; at fill_level=5, both for 40 cycles -> fill_level stays 5, data order preserved across pointer wrap.
- Random: 10k cycles of random wren/rden against a scoreboard queue -> data order and fill_level match, flags never disagree with fill_level, no overflow/underflow when the driver honours the flags.
